// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants and helpers for the prefetching fetch front end.
// Counter width helper sizes occupancy/outstanding/drop counters.
package fetch_prefetch_queue_pkg;

    localparam int PC_INCR    = 2;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction memory request/response bus.
// master = fetch unit, slave = instruction memory.
interface fetch_prefetch_queue_if
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Show-ahead synchronous FIFO with clear and entry count.
// Head word is visible on rdata whenever count is nonzero.
module sync_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled fetch front end: credit-limited in-order prefetch into a
// small FIFO, with redirect flush and dropping of stale responses.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_addr,
    input  logic                    halt,
    input  logic                    if_hold,
    fetch_prefetch_queue_if.master  mem,
    output logic                    if_valid,
    output logic [DATA_W-1:0]       if_instruction,
    output logic [ADDR_W-1:0]       if_pc,
    output logic [ADDR_W-1:0]       if_pc_next,
    output logic [cnt_w(DEPTH)-1:0] occupancy
);

    localparam int                CW     = cnt_w(DEPTH);
    localparam int                EW     = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] INCR   = ADDR_W'(PC_INCR);
    localparam logic [CW:0]       CREDIT = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW:0]       in_use;
    logic              issue;
    logic              keep;
    logic              pop;
    logic [EW-1:0]     head;

    // Entries held plus responses owed never exceed the FIFO depth.
    assign in_use   = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem.mem_req  = !reset && !halt && !redirect
                       && (in_use < CREDIT);
    assign mem.mem_addr = fetch_pc;

    assign issue = mem.mem_req && mem.mem_gnt;
    assign keep  = mem.mem_rvalid && !redirect
                && (drop_cnt == '0);
    assign pop   = if_valid && !if_hold;

    // resp_pc tracks the issue address of the next kept response.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_addr;
                resp_pc  <= redirect_addr;
                drop_cnt <= outstanding
                          - CW'(mem.mem_rvalid);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + INCR;
                end
                if (keep) begin
                    resp_pc <= resp_pc + INCR;
                end
                if (mem.mem_rvalid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
            outstanding <= outstanding + CW'(issue)
                         - CW'(mem.mem_rvalid);
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (redirect),
        .push  (keep),
        .pop   (pop),
        .wdata ({mem.mem_rdata, resp_pc}),
        .rdata (head),
        .count (occupancy)
    );

    assign if_valid       = (occupancy != '0);
    assign if_instruction = if_valid ? head[EW-1:ADDR_W] : '0;
    assign if_pc          = if_valid ? head[ADDR_W-1:0] : '0;
    assign if_pc_next     = if_valid ? if_pc + INCR : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised bench for fetch_prefetch_queue with an epoch-based
// reference model and a variable-latency in-order memory.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        halt = 1'b0;
    logic        if_hold = 1'b0;
    logic        if_valid;
    logic [15:0] if_instruction;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic [2:0]  occupancy;

    fetch_prefetch_queue_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (16),
        .DATA_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .if_hold        (if_hold),
        .mem            (mem_bus),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_next     (if_pc_next),
        .occupancy      (occupancy)
    );

    always #5 clock = ~clock;

    req_t        pend[$];
    ent_t        mq[$];
    logic [15:0] m_pc = 16'h0000;
    int          epoch = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          checks = 0;
    int          errors = 0;

    logic [68:0] obs;
    logic [68:0] exp_v;
    logic        s_req;
    logic [15:0] s_addr;
    logic        s_valid;
    logic [2:0]  s_occ;
    logic [15:0] s_ins;
    logic [15:0] s_pc;
    logic [15:0] s_pcn;

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // One clock: drive at negedge, sample #1 later, update model at posedge.
    task automatic step(input bit rst, input bit rd,
                        input logic [15:0] ra, input bit h,
                        input bit hold, input bit gnt);
        bit   rv;
        bit   exp_req;
        bit   pop;
        int   lat;
        req_t r;
        ent_t e;
        @(negedge clock);
        reset         = rst;
        redirect      = rd;
        redirect_addr = ra;
        halt          = h;
        if_hold       = hold;
        mem_bus.mem_gnt = gnt;
        rv = (pend.size() != 0) && (pend[0].due <= cyc);
        mem_bus.mem_rvalid = rv;
        mem_bus.mem_rdata  = rv ? data_of(pend[0].addr)
                                : 16'($urandom);
        #1;
        s_req   = mem_bus.mem_req;
        s_addr  = mem_bus.mem_addr;
        s_valid = if_valid;
        s_occ   = occupancy;
        s_ins   = if_instruction;
        s_pc    = if_pc;
        s_pcn   = if_pc_next;
        exp_req = !rst && !h && !rd
               && (mq.size() + pend.size() < DEPTH);
        e = '{16'h0, 16'h0};
        if (mq.size() != 0) e = mq[0];
        obs = {s_req, s_req ? s_addr : 16'h0, s_valid, s_occ,
               s_ins, s_pc, s_pcn};
        exp_v = {exp_req, exp_req ? m_pc : 16'h0,
                 mq.size() != 0, 3'(mq.size()), e.data, e.pc,
                 mq.size() != 0 ? 16'(e.pc + 16'd2) : 16'h0};
        @(posedge clock);
        if (rst) begin
            pend.delete();
            mq.delete();
            m_pc = 16'h0000;
            epoch++;
        end else begin
            pop = (mq.size() != 0) && !hold;
            if (rv) r = pend.pop_front();
            if (rd) begin
                mq.delete();
                epoch++;
                m_pc = ra;
            end else begin
                if (pop) void'(mq.pop_front());
                if (rv && r.epoch == epoch)
                    mq.push_back('{r.addr, data_of(r.addr)});
            end
            if (s_req && gnt) begin
                lat = $urandom_range(lat_max, lat_min);
                pend.push_back('{s_addr, epoch, cyc + lat});
            end
            if (exp_req && gnt) m_pc = m_pc + 16'd2;
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 0, 16'h0, 0, 0, 1);
        step(1, 0, 16'h0, 0, 0, 1);
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1;
        step(1, 0, 16'h0, 0, 0, 1);
        step(1, 0, 16'h0, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state obs=%h exp=%h", obs, exp_v);
        end
        checks++;
        if ({s_req, s_valid, s_occ, s_ins, s_pc, s_pcn} !== '0) begin
            errors++;
            $display("FAIL reset_zero obs=%b %b %h %h %h %h exp=0",
                     s_req, s_valid, s_occ, s_ins, s_pc, s_pcn);
        end
        step(0, 0, 16'h0, 0, 0, 1);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req obs=%b/%h exp=1/0000",
                     s_req, s_addr);
        end
    endtask

    task automatic test_sequential();
        int first = -1;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 16'h0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL seq obs=%h exp=%h", obs, exp_v);
            end
            if (s_valid === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL seq_first_valid obs=%0d exp=2", first);
        end
    endtask

    task automatic test_hold();
        logic [15:0] popped[$];
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 16'h0, 0, 1, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold obs=%h exp=%h", obs, exp_v);
            end
        end
        checks++;
        if (s_occ !== 3'd4 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_full obs=%0d/%b exp=4/0", s_occ, s_req);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 16'h0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold_drain obs=%h exp=%h", obs, exp_v);
            end
            if (s_valid === 1'b1) popped.push_back(s_pc);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= popped.size() || popped[i] !== 16'(2 * i)) begin
                errors++;
                $display("FAIL hold_order idx=%0d obs=%h exp=%h", i,
                         i < popped.size() ? popped[i] : 16'hxxxx,
                         16'(2 * i));
            end
        end
    endtask

    task automatic test_redirect_drop();
        logic [15:0] first_pc = 16'hxxxx;
        bit          seen = 0;
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 0, 1);
        step(0, 1, 16'h0100, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL redir_cycle obs=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 16'h0, 0, 0, 1);
            if (i == 0) begin
                checks++;
                if (s_occ !== 3'd0) begin
                    errors++;
                    $display("FAIL redir_empty obs=%0d exp=0", s_occ);
                end
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL redir_drop obs=%h exp=%h", obs, exp_v);
            end
            if (s_valid === 1'b1 && !seen) begin
                seen = 1;
                first_pc = s_pc;
            end
        end
        checks++;
        if (first_pc !== 16'h0100) begin
            errors++;
            $display("FAIL redir_first_pc obs=%h exp=0100", first_pc);
        end
    endtask

    task automatic test_redirect_same_cycle();
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0, 0, 1);
        step(0, 1, 16'h0200, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 16'h0, 0, 0, 1);
            if (i < 2) begin
                checks++;
                if (s_valid !== 1'b0 || s_occ !== 3'd0) begin
                    errors++;
                    $display("FAIL same_cycle_empty obs=%b/%0d exp=0/0",
                             s_valid, s_occ);
                end
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL same_cycle obs=%h exp=%h", obs, exp_v);
            end
        end
    endtask

    task automatic test_halt();
        lat_min = 3; lat_max = 3;
        do_reset();
        step(0, 0, 16'h0, 0, 1, 1);
        step(0, 0, 16'h0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 16'h0, 1, 1, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL halt obs=%h exp=%h", obs, exp_v);
            end
        end
        checks++;
        if (s_occ !== 3'd2 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold obs=%0d/%b exp=2/0", s_occ, s_req);
        end
        step(0, 0, 16'h0, 0, 0, 1);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 16'h0004) begin
            errors++;
            $display("FAIL halt_resume obs=%b/%h exp=1/0004",
                     s_req, s_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        lat_min = 1; lat_max = 1;
        do_reset();
        step(0, 1, 16'hFFFE, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'h0, 0, 1, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL wrap obs=%h exp=%h", obs, exp_v);
            end
        end
        checks++;
        if (s_pc !== 16'hFFFE || s_pcn !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_head obs=%h/%h exp=fffe/0000",
                     s_pc, s_pcn);
        end
        step(1, 0, 16'h0, 0, 1, 1);
        step(1, 0, 16'h0, 0, 1, 1);
        checks++;
        if ({s_req, s_valid, s_occ, s_ins, s_pc, s_pcn} !== '0) begin
            errors++;
            $display("FAIL reset_mid obs=%b %b %h %h %h %h exp=0",
                     s_req, s_valid, s_occ, s_ins, s_pc, s_pcn);
        end
    endtask

    task automatic test_random();
        bit          rst;
        bit          rd;
        bit          h;
        bit          hold;
        bit          gnt;
        logic [15:0] ra;
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(199) == 0);
            rd   = ($urandom_range(99) < 5);
            h    = ($urandom_range(99) < 10);
            hold = ($urandom_range(99) < 50);
            gnt  = ($urandom_range(99) < 70);
            ra   = 16'($urandom);
            step(rst, rd, ra, h, hold, gnt);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d obs=%h exp=%h",
                         cyc, obs, exp_v);
            end
            checks++;
            if (s_occ > 3'(DEPTH) || mq.size() > DEPTH) begin
                errors++;
                $display("FAIL overflow obs=%0d exp<=%0d",
                         s_occ, DEPTH);
            end
        end
    endtask

    initial begin
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
